mux_nto1_reg: RTL

- Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshake.
- Successor to the fixed 4-to-1 combinational select mux.
- Adds configurable width and channel count, a single output register stage, and an optional round-robin arbitration mode.
- Sits between multiple producer stages (e.g. writeback sources) and one consumer; supports full throughput with back-pressure.

---
 rtl/mux_nto1_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with per-channel valid/ready handshake.
// MODE 0 picks the channel from sel_i; MODE 1 picks it by round-robin arbitration.
module mux_nto1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SEL_W-1:0]        grant_o
);

  localparam bit RR = (MODE == 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_ch;
  logic             ch_vld;
  logic [SEL_W-1:0] ch;
  logic [WIDTH-1:0] ch_data;
  logic             xfer;
  int               rr_dist;
  int               rr_best;

  // Round-robin winner: the valid channel at the smallest forward distance from ptr.
  always_comb begin
    rr_vld  = 1'b0;
    rr_ch   = '0;
    rr_dist = 0;
    rr_best = NUM_CH;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_dist = k - int'(ptr_q);
      if (rr_dist < 0) begin
        rr_dist = rr_dist + NUM_CH;
      end else begin
        rr_dist = rr_dist;
      end
      if (in_valid_i[k] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_ch   = SEL_W'(k);
        rr_vld  = 1'b1;
      end else begin
        rr_best = rr_best;
      end
    end
  end

  // Channel choice, handshake and output-register next state.
  always_comb begin
    load_en = rst_n & (~out_valid_q | out_ready_i);
    if (RR) begin
      ch     = rr_ch;
      ch_vld = rr_vld;
    end else begin
      ch     = sel_i;
      ch_vld = (int'(sel_i) < NUM_CH);
    end

    ch_data    = '0;
    in_ready_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        ch_data       = in_data_i[k*WIDTH +: WIDTH];
        in_ready_o[k] = load_en & ch_vld;
      end else begin
        in_ready_o[k] = 1'b0;
      end
    end
    xfer = |(in_valid_i & in_ready_o);

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data;
      out_valid_d = 1'b1;
      grant_d     = ch;
      if (RR) begin
        // Explicit wrap keeps non-power-of-two channel counts correct.
        if (int'(ch) == NUM_CH - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = ch + SEL_W'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign grant_o     = grant_q;

endmodule
